// File: rtl/uart_rx.sv
// Oversampling UART receiver: start, Data_width data bits (LSB first), optional parity, one stop bit.
// Latency: result flags and P_DATA update in the cycle right after the last clock of the stop bit.
// Backpressure: none; the sink must take each one-cycle pulse when it appears. Requires Data_width >= 2.
module uart_rx #(
    parameter int Data_width = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [5:0]            Prescale,
    output logic [Data_width-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  Par_Err,
    output logic                  Stop_Err
);

    localparam int BCW = (Data_width > 1) ? $clog2(Data_width) : 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(Data_width - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state;
    logic [5:0]            edge_cnt;
    logic [BCW-1:0]        bit_cnt;
    logic [5:0]            pres_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic [Data_width-1:0] shift_q;
    logic                  par_bad;
    logic                  s0;
    logic                  s1;
    logic                  s2;

    // Prescale is captured at frame start so mid-frame changes cannot disturb the bit timing.
    logic [5:0] half;
    logic [5:0] last_edge;
    logic       bit_end;
    logic       maj;

    assign half      = {1'b0, pres_q[5:1]};
    assign last_edge = pres_q - 6'd1;
    assign bit_end   = (state != IDLE) && (edge_cnt == last_edge);
    // The three mid-bit samples are complete from edge half+2, well before bit_end uses them.
    assign maj       = (s0 & s1) | (s0 & s2) | (s1 & s2);

    // Capture three samples around the middle of each bit for the majority vote.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s0 <= 1'b1;
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else if (state != IDLE) begin
            if (edge_cnt == half - 6'd1) s0 <= RX_IN;
            if (edge_cnt == half)        s1 <= RX_IN;
            if (edge_cnt == half + 6'd1) s2 <= RX_IN;
        end
    end

    // Frame FSM with its counters, shift register, parity tracking and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            edge_cnt   <= 6'd0;
            bit_cnt    <= '0;
            pres_q     <= 6'd16;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            shift_q    <= '0;
            par_bad    <= 1'b0;
            P_DATA     <= '0;
            Data_Valid <= 1'b0;
            Par_Err    <= 1'b0;
            Stop_Err   <= 1'b0;
        end else begin
            Data_Valid <= 1'b0;
            Par_Err    <= 1'b0;
            Stop_Err   <= 1'b0;

            if (state != IDLE) begin
                edge_cnt <= bit_end ? 6'd0 : edge_cnt + 6'd1;
            end

            case (state)
                IDLE: begin
                    if (!RX_IN) begin
                        // The detecting cycle already counts as edge 0 of the start bit.
                        state     <= START;
                        edge_cnt  <= 6'd1;
                        bit_cnt   <= '0;
                        pres_q    <= Prescale;
                        par_en_q  <= PAR_EN;
                        par_typ_q <= PAR_TYP;
                        par_bad   <= 1'b0;
                    end
                end

                START: begin
                    // A start bit that votes high was a glitch: drop back without any output.
                    if (bit_end) state <= maj ? IDLE : DATA;
                end

                DATA: begin
                    if (bit_end) begin
                        shift_q <= {maj, shift_q[Data_width-1:1]};
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            state   <= par_en_q ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end

                PARITY: begin
                    if (bit_end) begin
                        par_bad <= (maj != ((^shift_q) ^ par_typ_q));
                        state   <= STOP;
                    end
                end

                STOP: begin
                    if (bit_end) begin
                        state    <= IDLE;
                        Par_Err  <= par_bad;
                        Stop_Err <= ~maj;
                        if (!par_bad && maj) begin
                            P_DATA     <= shift_q;
                            Data_Valid <= 1'b1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames, expected pulses queued at issue time.
// A negedge monitor pops the queue on every output pulse and checks flags, data and cycle.
// Any pulse with an empty queue or any leftover expectation at the end is an error.
module tb_uart_rx;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX_IN = 1'b1;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [5:0] Prescale = 6'd16;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       Par_Err;
    logic       Stop_Err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [7:0] last_good = 8'h00;

    typedef struct {
        logic [2:0] flags;   // {Data_Valid, Par_Err, Stop_Err}
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    uart_rx #(.Data_width(8)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .RX_IN     (RX_IN),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .Prescale  (Prescale),
        .P_DATA    (P_DATA),
        .Data_Valid(Data_Valid),
        .Par_Err   (Par_Err),
        .Stop_Err  (Stop_Err)
    );

    always #5 CLK = ~CLK;

    // cyc is the index of the cycle that began at the latest rising edge
    always @(posedge CLK) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every output pulse must match the oldest queued expectation
    always @(negedge CLK) begin
        if (!RST && (Data_Valid || Par_Err || Stop_Err)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: flags %b at cycle %0d, expected no pulse",
                         {Data_Valid, Par_Err, Stop_Err}, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("pulse_flags", 32'({Data_Valid, Par_Err, Stop_Err}), 32'(mon_e.flags));
                chk("pulse_data", 32'(P_DATA), 32'(mon_e.data));
                chk("pulse_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_bit(input logic b, input int p);
        RX_IN = b;
        repeat (p) @(posedge CLK);
        #1;
    endtask

    // Caller is #1 after a rising edge; the start bit begins in the current cycle.
    task automatic send(input logic [7:0] d, input int p, input bit pen, input bit ptyp,
                        input bit pbit, input bit stopb);
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        Prescale = 6'(p);
        drive_bit(1'b0, p);
        // Scramble the config after capture; the frame in flight must ignore it.
        PAR_EN   = ~pen;
        PAR_TYP  = ~ptyp;
        Prescale = (p == 8) ? 6'd16 : 6'd8;
        for (int i = 0; i < 8; i++) drive_bit(d[i], p);
        if (pen) drive_bit(pbit, p);
        drive_bit(stopb, p);
        RX_IN = 1'b1;
    endtask

    task automatic frame(input logic [7:0] d, input int p, input bit pen, input bit ptyp,
                         input bit pbit, input bit stopb,
                         input bit dv, input bit pe, input bit se);
        exp_t x;
        int   f;
        f       = 10 + (pen ? 1 : 0);
        x.flags = {dv, pe, se};
        x.data  = dv ? d : last_good;
        x.cyc   = cyc + f * p;
        exp_q.push_back(x);
        if (dv) last_good = d;
        send(d, p, pen, ptyp, pbit, stopb);
    endtask

    initial begin
        #1 RST = 1'b1;
        #2;
        chk("reset_p_data", 32'(P_DATA), 32'h0);
        chk("reset_data_valid", 32'(Data_Valid), 32'h0);
        chk("reset_par_err", 32'(Par_Err), 32'h0);
        chk("reset_stop_err", 32'(Stop_Err), 32'h0);
        step();
        RST = 1'b0;
        repeat (3) step();

        // P=8, no parity, 0xA5 -> valid 80 cycles after start
        frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        // P=16, even parity, 0x3C (four ones) with parity 0 -> valid at 176
        frame(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        // P=16, odd parity, 0x3C with parity 1 -> valid
        frame(8'h3C, 16, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        // P=16, even parity, 0x3C with parity 1 -> parity error, data held at 0x3C
        frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        // P=16, even parity, 0x3D (five ones) with parity 0 -> parity error, 0x3D not loaded
        frame(8'h3D, 16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        // P=32, no parity, 0x81 with stop bit 0 -> stop error at 320
        frame(8'h81, 32, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (4) step();
        frame(8'h7E, 32, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        // Glitch: low for 3 cycles at P=16; new frame starts exactly at cycle 16
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        Prescale = 6'd16;
        RX_IN    = 1'b0;
        repeat (3) step();
        RX_IN = 1'b1;
        repeat (13) step();
        frame(8'h55, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        // Both errors together: 0x01 even parity expects 1, send 0, stop 0
        frame(8'h01, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (4) step();

        // Back-to-back frames with no idle gap
        frame(8'h12, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        frame(8'h34, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        // Third frame aborted by reset after start + 3 data bits
        PAR_EN   = 1'b0;
        Prescale = 6'd8;
        drive_bit(1'b0, 8);
        drive_bit(1'b1, 8);
        drive_bit(1'b0, 8);
        drive_bit(1'b1, 8);
        RST = 1'b1;
        #1;
        chk("midrst_p_data", 32'(P_DATA), 32'h0);
        chk("midrst_data_valid", 32'(Data_Valid), 32'h0);
        chk("midrst_par_err", 32'(Par_Err), 32'h0);
        chk("midrst_stop_err", 32'(Stop_Err), 32'h0);
        RX_IN = 1'b1;
        step();
        RST = 1'b0;
        last_good = 8'h00;
        repeat (3) step();
        frame(8'hC3, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        repeat (20) step();
        chk("pending_expectations", 32'(exp_q.size()), 32'h0);
        chk("final_p_data", 32'(P_DATA), 32'hC3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Oversampling UART receiver: the receive-side counterpart of the team's UART transmitter. It reconstructs frames of start bit, `Data_width` data bits (LSB first), an optional parity bit and one stop bit from the serial line `RX_IN`. For each error-free frame it presents the parallel word with a one-cycle valid pulse. It sits in the UART block next to the transmitter and shares its parity configuration (`PAR_EN`, `PAR_TYP`). `RX_IN` is already synchronised to `CLK` by the top level.

## Interface
- `Data_width`, 8, number of data bits per frame
- `CLK`  input  1  receiver clock, `Prescale` × bit rate
- `RST`  input  1  reset, asynchronous, active-high
- `RX_IN`  input  1  serial line, idle high
- `PAR_EN`  input  1  1 = a parity bit follows the data bits
- `PAR_TYP`  input  1  0 = even parity, 1 = odd parity
- `Prescale`  input  6  oversampling ratio; legal values are 8, 16 and 32
- `P_DATA`  output  `Data_width`  last correctly received word
- `Data_Valid`  output  1  one-cycle pulse when a good frame completes
- `Par_Err`  output  1  one-cycle pulse when a frame completes with a parity mismatch
- `Stop_Err`  output  1  one-cycle pulse when a frame completes with stop bit sampled 0

## Operation
- States:
  - IDLE: wait for `RX_IN`=0.
  - START: check the start bit.
  - DATA: receive `Data_width` bits.
  - PARITY: entered only if `PAR_EN`=1.
  - STOP: check the stop bit, then return to IDLE.
- Counters:
  - `edge_cnt` runs 0..`Prescale`-1 within each bit.
  - `bit_cnt` runs 0..`Data_width`-1 within DATA.
- Configuration capture: `PAR_EN`, `PAR_TYP` and `Prescale` are registered on the IDLE→START transition. Changes during a frame have no effect on that frame.
- Bit sampling:
  - Sample `RX_IN` at `edge_cnt` = P/2-1, P/2 and P/2+1, where P is the captured prescale.
  - The bit value is the 2-of-3 majority of these samples.
  - The value is valid from `edge_cnt` = P/2+2 onward.
- Start check: if the START majority is 1, it is a glitch. Return to IDLE at the end of that bit, with no outputs asserted.
- Data: shift bits into an internal register LSB first. `P_DATA` is not touched during reception.
- Parity check:
  - Expected parity = XOR of the data bits when `PAR_TYP`=0, and its inverse when `PAR_TYP`=1.
  - A mismatch with the sampled parity bit is a parity error.
- Frame completion, at the last clock of the stop bit (`edge_cnt`=P-1):
  - No error: load `P_DATA` with the shift register and pulse `Data_Valid`.
  - Parity error: pulse `Par_Err`.
  - Stop bit sampled 0: pulse `Stop_Err`.
  - Both errors may pulse together. `P_DATA` keeps its old value on any error.
- After completion the FSM is in IDLE, so a new start bit can be detected in the very next cycle. Back-to-back frames need no idle gap.
- Reset (asynchronous, any time including mid-frame):
  - FSM returns to IDLE; counters and shift register are cleared.
  - `P_DATA`=0, `Data_Valid`=0, `Par_Err`=0, `Stop_Err`=0.
  - A partially received frame is discarded.

## Timing
- Cycle 0 is the first cycle in which IDLE sees `RX_IN`=0. That cycle counts as `edge_cnt`=0 of the start bit.
- Frame bit k occupies cycles k·P to k·P+P-1.
- F = 2 + `Data_width` + `PAR_EN` (number of frame bits).
- `Data_Valid`, `Par_Err` and `Stop_Err` are high only in cycle F·P, for exactly one cycle.
- `P_DATA` changes at the start of cycle F·P and then holds.
- If `RX_IN`=0 in cycle F·P, that cycle is cycle 0 of the next frame.
- Glitch rejection: the FSM is back in IDLE in cycle P. No output changes.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- P=8, `PAR_EN`=0, send 0xA5 → `Data_Valid` high only in cycle 80, `P_DATA`=0xA5, both error flags stay 0.
- P=16, `PAR_EN`=1, `PAR_TYP`=0, send 0x3C with parity 0 → `Data_Valid` in cycle 176, `P_DATA`=0x3C. Repeat with `PAR_TYP`=1 and parity 1 → same result.
- P=16, even parity, send 0x3C with parity 1 → `Par_Err` pulse in cycle 176, `Data_Valid`=0, `P_DATA` keeps its previous value.
- P=32, `PAR_EN`=0, send 0x81 with stop bit 0 → `Stop_Err` pulse in cycle 320, no `Data_Valid`. Then send a good 0x7E → `Data_Valid` with `P_DATA`=0x7E.
- P=16, drive `RX_IN` low for 3 cycles only, then high → no output pulses, FSM in IDLE by cycle 16. An immediately following good 0x55 frame is received correctly.
- P=8, send two back-to-back frames 0x12 and 0x34 with no gap → pulses in cycles 80 and 160 with the matching `P_DATA`. Then assert `RST` mid-way through a third frame → all outputs 0 at once, no pulse for the aborted frame, and the next full frame is received correctly.
